// File: rtl/timing_gen_if.sv
// timing_gen_if -- signal bundle between the instruction-cycle sequencer and
// the hardwired controller that drives it.
//   qd                  start/continue request (rising edge acts)
//   short, long, stop   beat-control requests, looked at only in T4
//   t1..t4              one-hot phase pulses
//   w1..w3              one-hot current beat, zero while idle
//   running             sequencer active
//   icount              completed-instruction count (wraps at 255)
interface timing_gen_if;
    logic       qd;
    logic       short;
    logic       long;
    logic       stop;
    logic       t1;
    logic       t2;
    logic       t3;
    logic       t4;
    logic       w1;
    logic       w2;
    logic       w3;
    logic       running;
    logic [7:0] icount;

    modport master (
        output qd, short, long, stop,
        input  t1, t2, t3, t4, w1, w2, w3, running, icount
    );

    modport slave (
        input  qd, short, long, stop,
        output t1, t2, t3, t4, w1, w2, w3, running, icount
    );
endinterface

// File: rtl/timing_gen.sv
// timing_gen -- instruction-cycle timing generator.
// Steps through phases T1..T4 within each beat (W1/W2/W3) while running.
// At the end of T4 the next beat is chosen from short/long, stop can halt
// the sequencer, and icount counts every return to W1.
// Ports:
//   clk   system clock, rising edge
//   clr   asynchronous active-high reset
//   bus   timing_gen_if.slave (qd/short/long/stop in; t*/w*/running/icount out)
//
// state   | meaning
// --------+-----------------------------------------------
// PH_T1   | first phase of the beat (also the idle phase)
// PH_T2   | second phase
// PH_T3   | third phase
// PH_T4   | last phase; beat control inputs sampled here
module timing_gen (
    input logic         clk,
    input logic         clr,
    timing_gen_if.slave bus
);

    typedef enum logic [1:0] {PH_T1, PH_T2, PH_T3, PH_T4} phase_t;
    typedef enum logic [1:0] {BEAT_W1, BEAT_W2, BEAT_W3} beat_t;

    phase_t     phase, phase_n;
    beat_t      beat, beat_n;
    logic       running, running_n;
    logic [7:0] icount, icount_n;
    logic       qd_prev;
    logic       start;
    logic [3:0] t_q;
    logic [2:0] w_q;

    always_comb begin
        start     = bus.qd & ~qd_prev;
        running_n = running;
        phase_n   = phase;
        beat_n    = beat;
        icount_n  = icount;
        if (!running) begin
            phase_n = PH_T1;
            if (start) running_n = 1'b1;
        end else begin
            case (phase)
                PH_T1: phase_n = PH_T2;
                PH_T2: phase_n = PH_T3;
                PH_T3: phase_n = PH_T4;
                PH_T4: begin
                    phase_n = PH_T1;
                    case (beat)
                        BEAT_W1: beat_n = bus.short ? BEAT_W1 : BEAT_W2;
                        BEAT_W2: beat_n = bus.long  ? BEAT_W3 : BEAT_W1;
                        default: beat_n = BEAT_W1;
                    endcase
                    if (bus.stop) running_n = 1'b0;
                    // an instruction completes whenever the beat returns to W1,
                    // even when the sequencer is stopping at this edge
                    if (beat_n == BEAT_W1) icount_n = icount + 8'd1;
                end
                default: phase_n = PH_T1;
            endcase
        end
    end

    // t/w outputs are registered from the next-state values so they line up
    // with phase/beat and drop to zero the instant clr asserts.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            phase   <= PH_T1;
            beat    <= BEAT_W1;
            running <= 1'b0;
            icount  <= 8'd0;
            qd_prev <= 1'b1;
            t_q     <= 4'b0000;
            w_q     <= 3'b000;
        end else begin
            phase   <= phase_n;
            beat    <= beat_n;
            running <= running_n;
            icount  <= icount_n;
            qd_prev <= bus.qd;
            t_q     <= {running_n && (phase_n == PH_T1),
                        running_n && (phase_n == PH_T2),
                        running_n && (phase_n == PH_T3),
                        running_n && (phase_n == PH_T4)};
            w_q     <= {running_n && (beat_n == BEAT_W1),
                        running_n && (beat_n == BEAT_W2),
                        running_n && (beat_n == BEAT_W3)};
        end
    end

    assign bus.t1      = t_q[3];
    assign bus.t2      = t_q[2];
    assign bus.t3      = t_q[1];
    assign bus.t4      = t_q[0];
    assign bus.w1      = w_q[2];
    assign bus.w2      = w_q[1];
    assign bus.w3      = w_q[0];
    assign bus.running = running;
    assign bus.icount  = icount;

endmodule
